cp0_exc_unit: RTL and testbench

- Coprocessor-0 exception responder for the pipelined MIPS core.
- Consumes the per-instruction exception tuple (BD flag, victim PC, ExcCode) carried down the pipeline registers, plus the external hardware interrupt lines.
- Decides whether to take an exception. Drives `Req` and `EPCOut` back to the fetch/decode pipeline registers, which redirect to the handler or return on ERET.
- Sits at the memory stage alongside the data-memory interface. Also serves `mtc0`/`mfc0` accesses.

---
 rtl/cp0_exc_unit_if.sv | 27 ++
 rtl/cp0_exc_unit.sv | 135 +++++++++++++
 tb/tb_cp0_exc_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_unit_if.sv
// Pipeline <-> CP0 exception responder bundle: mtc0/mfc0 access, the M-stage
// exception tuple, external interrupt lines, and the Req/EPC redirect outputs.
interface cp0_exc_unit_if;
    logic [4:0]  CP0Add;
    logic [31:0] CP0In;
    logic        CP0WE;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    // Pipeline side: drives the access and exception tuple, consumes the redirect.
    modport master (
        output CP0Add, CP0In, CP0WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        input  CP0Out, EPCOut, Req
    );

    // CP0 side.
    modport slave (
        input  CP0Add, CP0In, CP0WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        output CP0Out, EPCOut, Req
    );
endinterface

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception responder: SR/Cause/EPC, request logic, mtc0/mfc0.
// Optional Count/Compare timer (regs 9/11, Cause.TI) built when CP0_TIMER_EN is defined.
module cp0_exc_unit (
    input  logic             clk,
    input  logic             RESET_N,
    cp0_exc_unit_if.slave    bus
);
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    logic [5:0]  im_reg;
    logic        exl_reg;
    logic        ie_reg;
    logic        bd_reg;
    logic [5:0]  ip_reg;
    logic [4:0]  exc_code_reg;
    logic [31:0] epc_reg;

    logic        timer_hit;
    logic        ti_bit;
    logic [5:0]  int_src;
    logic [5:0]  int_pending;
    logic        int_req;
    logic        exc_req;
    logic        req;
    logic        wr_sr;
    logic        wr_epc;
    logic [31:0] epc_next;
    logic [31:0] rd_data;

`ifdef CP0_TIMER_EN
    logic [31:0] count_reg;
    logic [31:0] compare_reg;
    logic        ti_reg;
    logic        wr_count;
    logic        wr_compare;

    // The match is seen combinationally so the interrupt fires in the cycle Count equals Compare.
    assign timer_hit  = ti_reg | (count_reg == compare_reg);
    assign ti_bit     = ti_reg;
    assign wr_count   = bus.CP0WE & ~req & (bus.CP0Add == REG_COUNT);
    assign wr_compare = bus.CP0WE & ~req & (bus.CP0Add == REG_COMPARE);

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            count_reg   <= 32'd0;
            compare_reg <= 32'hFFFF_FFFF;
            ti_reg      <= 1'b0;
        end else begin
            count_reg <= wr_count ? bus.CP0In : count_reg + 32'd1;
            if (wr_compare) begin
                compare_reg <= bus.CP0In;
                ti_reg      <= 1'b0;
            end else if (count_reg == compare_reg) begin
                ti_reg <= 1'b1;
            end
        end
    end
`else
    assign timer_hit = 1'b0;
    assign ti_bit    = 1'b0;
`endif

    assign int_src = {bus.HWInt[5] | timer_hit, bus.HWInt[4:0]};

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_int_mask
            assign int_pending[gi] = int_src[gi] & im_reg[gi];
        end
    endgenerate

    assign int_req = (|int_pending) & ie_reg & ~exl_reg;
    assign exc_req = (bus.ExcCodeIn != 5'd0) & ~exl_reg;
    // Reset state would otherwise let a nonzero ExcCodeIn through while EXL is 0.
    assign req     = (int_req | exc_req) & RESET_N;
    assign bus.Req = req;

    assign wr_sr    = bus.CP0WE & ~req & (bus.CP0Add == REG_SR);
    assign wr_epc   = bus.CP0WE & ~req & (bus.CP0Add == REG_EPC);
    assign epc_next = bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            im_reg       <= 6'd0;
            exl_reg      <= 1'b0;
            ie_reg       <= 1'b0;
            bd_reg       <= 1'b0;
            ip_reg       <= 6'd0;
            exc_code_reg <= 5'd0;
            epc_reg      <= 32'd0;
        end else begin
            ip_reg <= int_src;
            if (req) begin
                exl_reg      <= 1'b1;
                bd_reg       <= bus.BDIn;
                epc_reg      <= epc_next;
                exc_code_reg <= int_req ? 5'd0 : bus.ExcCodeIn;
            end else begin
                if (wr_sr) begin
                    im_reg  <= bus.CP0In[15:10];
                    exl_reg <= bus.CP0In[1];
                    ie_reg  <= bus.CP0In[0];
                end
                // Placed after the SR write so ERET overrides an mtc0 to EXL.
                if (bus.EXLClr) begin
                    exl_reg <= 1'b0;
                end
                if (wr_epc) begin
                    epc_reg <= bus.CP0In;
                end
            end
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (bus.CP0Add)
            REG_SR:    rd_data = {16'd0, im_reg, 8'd0, exl_reg, ie_reg};
            REG_CAUSE: rd_data = {bd_reg, ti_bit, 14'd0, ip_reg, 3'd0, exc_code_reg, 2'd0};
            REG_EPC:   rd_data = epc_reg;
`ifdef CP0_TIMER_EN
            REG_COUNT:   rd_data = count_reg;
            REG_COMPARE: rd_data = compare_reg;
`endif
            default:   rd_data = 32'd0;
        endcase
    end

    assign bus.CP0Out = rd_data;
    assign bus.EPCOut = epc_reg;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Scoreboard bench for cp0_exc_unit: expectations queued with each stimulus,
// drained and compared once the combinational outputs settle in the low clock phase.
module tb_cp0_exc_unit;
    logic clk;
    logic RESET_N;

    cp0_exc_unit_if bus ();

    cp0_exc_unit dut (
        .clk     (clk),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    typedef enum logic [1:0] {OBS_REQ, OBS_EPC, OBS_OUT, OBS_TI} obs_e;
    typedef struct {
        string       tag;
        obs_e        obs;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s got=%h", tag, got);
        end
    endtask

    task automatic push_exp(input string tag, input obs_e obs, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.obs = obs;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic drain();
        sb_item_t it;
        logic [31:0] got;
        #1;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            case (it.obs)
                OBS_REQ: got = {31'd0, bus.Req};
                OBS_EPC: got = bus.EPCOut;
                OBS_OUT: got = bus.CP0Out;
                default: got = {31'd0, bus.CP0Out[30]};
            endcase
            check_eq(it.tag, got, it.exp);
        end
    endtask

    task automatic expect_reg(input logic [4:0] addr, input logic [31:0] exp, input string tag);
        bus.CP0Add = addr;
        push_exp(tag, OBS_OUT, exp);
        drain();
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        bus.CP0WE  = 1'b1;
        bus.CP0Add = addr;
        bus.CP0In  = data;
        tick();
        bus.CP0WE  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N       = 1'b1;
        bus.CP0Add    = 5'd0;
        bus.CP0In     = 32'd0;
        bus.CP0WE     = 1'b0;
        bus.VPC       = 32'd0;
        bus.BDIn      = 1'b0;
        bus.ExcCodeIn = 5'd4;
        bus.HWInt     = 6'h3F;
        bus.EXLClr    = 1'b0;
        #2 RESET_N = 1'b0;
        tick();

        // Reset holds everything at zero even with live requests.
        bus.CP0Add = 5'd12;
        push_exp("rst_req", OBS_REQ, 32'd0);
        push_exp("rst_epc", OBS_EPC, 32'd0);
        push_exp("rst_sr", OBS_OUT, 32'd0);
        drain();
        expect_reg(5'd13, 32'd0, "rst_cause");
        expect_reg(5'd14, 32'd0, "rst_epcreg");
        bus.ExcCodeIn = 5'd0;
        bus.HWInt     = 6'h00;
        RESET_N       = 1'b1;
        tick();

        // Exception in a branch delay slot.
        bus.ExcCodeIn = 5'd10;
        bus.BDIn      = 1'b1;
        bus.VPC       = 32'h0000_3008;
        push_exp("dly_req", OBS_REQ, 32'd1);
        drain();
        tick();
        push_exp("dly_epc", OBS_EPC, 32'h0000_3004);
        push_exp("dly_block", OBS_REQ, 32'd0);
        drain();
        expect_reg(5'd13, 32'h8000_0028, "dly_cause");
        expect_reg(5'd12, 32'h0000_0002, "dly_sr");
        bus.ExcCodeIn = 5'd0;
        bus.BDIn      = 1'b0;
        bus.EXLClr    = 1'b1;
        tick();
        bus.EXLClr = 1'b0;
        expect_reg(5'd12, 32'h0000_0000, "eret1_sr");

        // Interrupt beats a simultaneous exception.
        wr(5'd12, 32'h0000_0401);
        bus.HWInt     = 6'h01;
        bus.ExcCodeIn = 5'd12;
        bus.VPC       = 32'h0000_3010;
        push_exp("irq_req", OBS_REQ, 32'd1);
        drain();
        tick();
        push_exp("irq_block", OBS_REQ, 32'd0);
        push_exp("irq_epc", OBS_EPC, 32'h0000_3010);
        drain();
        expect_reg(5'd13, 32'h0000_0400, "irq_cause");
        expect_reg(5'd12, 32'h0000_0403, "irq_sr");

        // ERET with the interrupt still pending re-raises Req.
        bus.ExcCodeIn = 5'd0;
        bus.EXLClr    = 1'b1;
        push_exp("eret_hold", OBS_REQ, 32'd0);
        drain();
        tick();
        bus.EXLClr = 1'b0;
        push_exp("eret_rereq", OBS_REQ, 32'd1);
        drain();
        expect_reg(5'd12, 32'h0000_0401, "eret_sr");

        // mtc0 to EPC in the Req cycle is dropped.
        bus.VPC    = 32'h0000_3020;
        bus.CP0WE  = 1'b1;
        bus.CP0Add = 5'd14;
        bus.CP0In  = 32'hDEAD_0000;
        push_exp("sup_req", OBS_REQ, 32'd1);
        drain();
        tick();
        bus.CP0WE = 1'b0;
        push_exp("sup_epc", OBS_EPC, 32'h0000_3020);
        drain();
        bus.HWInt  = 6'h00;
        bus.EXLClr = 1'b1;
        tick();
        bus.EXLClr = 1'b0;
        push_exp("idle_req", OBS_REQ, 32'd0);
        drain();
        expect_reg(5'd13, 32'h0000_0000, "idle_cause");

        // Plain writes, read-only Cause, unmapped registers.
        wr(5'd14, 32'hDEAD_0000);
        push_exp("wr_epcout", OBS_EPC, 32'hDEAD_0000);
        drain();
        expect_reg(5'd14, 32'hDEAD_0000, "wr_epc");
        wr(5'd13, 32'hFFFF_FFFF);
        expect_reg(5'd13, 32'h0000_0000, "cause_ro");
        wr(5'd5, 32'h1234_5678);
        expect_reg(5'd5, 32'h0000_0000, "unmapped");
`ifndef CP0_TIMER_EN
        wr(5'd9, 32'h1234_5678);
        expect_reg(5'd9, 32'h0000_0000, "no_count");
        expect_reg(5'd11, 32'h0000_0000, "no_compare");
`endif

        // ERET and mtc0 SR together: EXL ends up clear.
        bus.EXLClr = 1'b1;
        wr(5'd12, 32'hFFFF_FFFF);
        bus.EXLClr = 1'b0;
        expect_reg(5'd12, 32'h0000_FC01, "eret_mtc0");

        // Delay-slot EPC wraps below zero; EXL blocks nested interrupts.
        bus.ExcCodeIn = 5'd4;
        bus.BDIn      = 1'b1;
        bus.VPC       = 32'h0000_0000;
        push_exp("wrap_req", OBS_REQ, 32'd1);
        drain();
        tick();
        bus.ExcCodeIn = 5'd0;
        bus.BDIn      = 1'b0;
        push_exp("wrap_epc", OBS_EPC, 32'hFFFF_FFFC);
        drain();
        expect_reg(5'd13, 32'h8000_0010, "wrap_cause");
        bus.HWInt = 6'h3F;
        push_exp("nest_block", OBS_REQ, 32'd0);
        drain();
        tick();
        expect_reg(5'd13, 32'h8000_FC10, "nest_ip");
        bus.HWInt  = 6'h00;
        bus.EXLClr = 1'b1;
        tick();
        bus.EXLClr = 1'b0;

        // Cause.IP lags HWInt by one edge; masked lines raise nothing.
        wr(5'd12, 32'h0000_0001);
        bus.HWInt = 6'h2A;
        push_exp("mask_req", OBS_REQ, 32'd0);
        drain();
        expect_reg(5'd13, 32'h8000_0010, "ip_before");
        tick();
        expect_reg(5'd13, 32'h8000_A810, "ip_after");
        bus.HWInt = 6'h00;
        tick();

`ifdef CP0_TIMER_EN
        begin
            bit hit;
            wr(5'd11, 32'd5);
            wr(5'd9, 32'd0);
            wr(5'd12, 32'h0000_8001);
            bus.CP0Add = 5'd9;
            hit = 1'b0;
            for (int i = 0; i < 20 && !hit; i++) begin
                #1;
                if (bus.Req) hit = 1'b1;
                else tick();
            end
            push_exp("tmr_req", OBS_REQ, 32'd1);
            push_exp("tmr_count", OBS_OUT, 32'd5);
            drain();
            tick();
            bus.CP0Add = 5'd13;
            push_exp("tmr_ti_set", OBS_TI, 32'd1);
            drain();
            wr(5'd11, 32'd100);
            bus.CP0Add = 5'd13;
            push_exp("tmr_ti_clr", OBS_TI, 32'd0);
            drain();
            bus.EXLClr = 1'b1;
            tick();
            bus.EXLClr = 1'b0;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
